// File: rtl/line_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : line_buffer_pkg                                                   |
// | Desc   : Shared mode encodings and the fill-target helper for the          |
// |          multi-topology line buffer.                                       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package line_buffer_pkg;

  localparam logic MODE_CHAIN = 1'b0;
  localparam logic MODE_SPLIT = 1'b1;

  // Number of shifts needed before the window is fully populated:
  // the whole chain in CHAIN mode, one segment in SPLIT mode.
  function automatic int unsigned fill_target(input logic mode,
                                              input int unsigned depth,
                                              input int unsigned nch);
    return (mode == MODE_SPLIT) ? (depth / nch) : depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer_seg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : line_buffer_seg                                                   |
// | Desc   : One SEG-deep shift segment of line registers with valid bits.     |
// |          The head row takes the channel line, an all-zero line, or the     |
// |          tail of the previous segment when segments are chained.           |
// | Ports  : clk, rst        clock / sync active-high reset                    |
// |          i_clr           clear valid bits only                             |
// |          i_shift         advance the segment by one row                    |
// |          i_link          head takes i_link_data / i_link_valid             |
// |          i_zero          head takes an all-zero (valid) line               |
// |          i_ch_data       this segment's input channel line                 |
// |          i_link_data/_valid  tail row of the previous segment              |
// |          o_data, o_valid row r at [r*LINE_W +: LINE_W]; row 0 = head       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module line_buffer_seg
  import line_buffer_pkg::*;
#(
  parameter int LINE_W = 16,
  parameter int SEG    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_shift,
  input  logic                  i_link,
  input  logic                  i_zero,
  input  logic [LINE_W-1:0]     i_ch_data,
  input  logic [LINE_W-1:0]     i_link_data,
  input  logic                  i_link_valid,
  output logic [SEG*LINE_W-1:0] o_data,
  output logic [SEG-1:0]        o_valid
);

  logic [LINE_W-1:0] r_row [SEG];
  logic [SEG-1:0]    r_valid;
  logic [LINE_W-1:0] w_head_data;
  logic              w_head_valid;

  assign w_head_data  = i_zero ? '0 : (i_link ? i_link_data : i_ch_data);
  assign w_head_valid = i_link ? i_link_valid : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SEG; i++) r_row[i] <= '0;
      r_valid <= '0;
    end else if (i_clr) begin
      // Data is intentionally retained; only occupancy is forgotten.
      r_valid <= '0;
    end else if (i_shift) begin
      r_row[0]   <= w_head_data;
      r_valid[0] <= w_head_valid;
      for (int i = 1; i < SEG; i++) begin
        r_row[i]   <= r_row[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  for (genvar i = 0; i < SEG; i++) begin : g_pack
    assign o_data[i*LINE_W +: LINE_W] = r_row[i];
  end
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/line_buffer_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : line_buffer_multi                                                 |
// | Desc   : DEPTH-row line buffer, runtime selectable as one long chain       |
// |          (CHAIN) or NCH independent SEG-deep chains (SPLIT). Tracks row    |
// |          occupancy, fill count and a primed flag; valid/ready input with   |
// |          consumer hold, flush and zero-fill.                               |
// | Ports  : clk, rst, mode, flush, hold, fill_zero, in_valid, in_ready,       |
// |          in_data (NCH lines), buf_data (DEPTH lines, row 0 newest),        |
// |          row_valid, fill_cnt, primed                                       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module line_buffer_multi
  import line_buffer_pkg::*;
#(
  parameter int LINE_W = 5120,
  parameter int DEPTH  = 10,
  parameter int NCH    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic                       flush,
  input  logic                       hold,
  input  logic                       fill_zero,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NCH*LINE_W-1:0]      in_data,
  output logic [DEPTH*LINE_W-1:0]    buf_data,
  output logic [DEPTH-1:0]           row_valid,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
  output logic                       primed
);

  localparam int SEG   = DEPTH / NCH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             r_mode_q;
  logic [CNT_W-1:0] r_fill_cnt;
  logic             r_primed;

  logic             w_mode_chg;
  logic             w_clr;
  logic             w_shift;
  logic [CNT_W-1:0] w_target;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_mode_chg = (mode != r_mode_q);
  assign w_clr      = flush || w_mode_chg;
  assign in_ready   = !hold && !flush && !w_mode_chg;
  assign w_shift    = in_ready && (in_valid || fill_zero);

  // Target follows the registered mode: shifts only happen when mode == mode_q.
  assign w_target  = CNT_W'(fill_target(r_mode_q, DEPTH, NCH));
  assign w_cnt_nxt = (r_fill_cnt < w_target) ? r_fill_cnt + 1'b1 : r_fill_cnt;

  for (genvar c = 0; c < NCH; c++) begin : g_seg
    // Row feeding this segment's head in CHAIN mode (unused for segment 0).
    localparam int LINK_ROW = (c == 0) ? 0 : c * SEG - 1;

    logic w_link;
    logic w_zero;

    assign w_link = (r_mode_q == MODE_CHAIN) && (c != 0);
    // In CHAIN mode only the true chain head sees the zero line.
    assign w_zero = fill_zero && ((r_mode_q == MODE_SPLIT) || (c == 0));

    line_buffer_seg #(
      .LINE_W (LINE_W),
      .SEG    (SEG)
    ) u_seg (
      .clk          (clk),
      .rst          (rst),
      .i_clr        (w_clr),
      .i_shift      (w_shift),
      .i_link       (w_link),
      .i_zero       (w_zero),
      .i_ch_data    (in_data[c*LINE_W +: LINE_W]),
      .i_link_data  (buf_data[LINK_ROW*LINE_W +: LINE_W]),
      .i_link_valid (row_valid[LINK_ROW]),
      .o_data       (buf_data[c*SEG*LINE_W +: SEG*LINE_W]),
      .o_valid      (row_valid[c*SEG +: SEG])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q   <= MODE_CHAIN;
      r_fill_cnt <= '0;
      r_primed   <= 1'b0;
    end else if (w_clr) begin
      r_mode_q   <= mode;
      r_fill_cnt <= '0;
      r_primed   <= 1'b0;
    end else if (w_shift) begin
      r_fill_cnt <= w_cnt_nxt;
      r_primed   <= (w_cnt_nxt == w_target);
    end
  end

  assign fill_cnt = r_fill_cnt;
  assign primed   = r_primed;

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_line_buffer_multi                                              |
// | Desc   : Self-checking bench for line_buffer_multi (LINE_W=16, DEPTH=10,   |
// |          NCH=5) against a behavioural row-array model.                     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_line_buffer_multi;

  localparam int LW = 16;
  localparam int D  = 10;
  localparam int N  = 5;

  logic          clk = 1'b0;
  logic          rst, mode, flush, hold, fill_zero, in_valid;
  logic          in_ready;
  logic [N*LW-1:0] in_data;
  logic [D*LW-1:0] buf_data;
  logic [D-1:0]    row_valid;
  logic [3:0]      fill_cnt;
  logic            primed;

  line_buffer_multi #(.LINE_W(LW), .DEPTH(D), .NCH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .flush     (flush),
    .hold      (hold),
    .fill_zero (fill_zero),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .buf_data  (buf_data),
    .row_valid (row_valid),
    .fill_cnt  (fill_cnt),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [LW-1:0] m_row [D];
  logic          m_val [D];
  int            m_cnt;
  logic          m_primed;
  logic          m_mode;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [D*LW-1:0] act, input logic [D*LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] row(input int r);
    return buf_data[r*LW +: LW];
  endfunction

  function automatic logic [D*LW-1:0] m_buf();
    logic [D*LW-1:0] v;
    for (int r = 0; r < D; r++) v[r*LW +: LW] = m_row[r];
    return v;
  endfunction

  function automatic logic [D-1:0] m_valid();
    logic [D-1:0] v;
    for (int r = 0; r < D; r++) v[r] = m_val[r];
    return v;
  endfunction

  // Next state from the rules: rows at multiples of the chain length are
  // heads fed by channel (row / chain length); every other row takes its
  // upper neighbour.
  task automatic model_update();
    logic [LW-1:0] nrow [D];
    logic          nval [D];
    int            seg;
    if (rst) begin
      for (int r = 0; r < D; r++) begin m_row[r] = '0; m_val[r] = 1'b0; end
      m_cnt = 0; m_primed = 1'b0; m_mode = 1'b0;
    end else if (flush || (mode != m_mode)) begin
      for (int r = 0; r < D; r++) m_val[r] = 1'b0;
      m_cnt = 0; m_primed = 1'b0; m_mode = mode;
    end else if (!hold && (in_valid || fill_zero)) begin
      seg = m_mode ? D / N : D;
      for (int r = 0; r < D; r++) begin
        if (r % seg == 0) begin
          nrow[r] = fill_zero ? '0 : in_data[(r / seg)*LW +: LW];
          nval[r] = 1'b1;
        end else begin
          nrow[r] = m_row[r-1];
          nval[r] = m_val[r-1];
        end
      end
      for (int r = 0; r < D; r++) begin m_row[r] = nrow[r]; m_val[r] = nval[r]; end
      if (m_cnt < seg) m_cnt++;
      m_primed = (m_cnt == seg);
    end
  endtask

  // One clock: check the combinational ready, advance model, check outputs.
  task automatic step();
    #1;
    if (!rst) check("in_ready", in_ready, !hold && !flush && (mode == m_mode));
    model_update();
    @(posedge clk);
    #1;
    check("buf_data",  buf_data,  m_buf());
    check("row_valid", row_valid, m_valid());
    check("fill_cnt",  fill_cnt,  m_cnt[3:0]);
    check("primed",    primed,    m_primed);
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; hold = 0; fill_zero = 0; in_valid = 0;
  endtask

  task automatic rand_data();
    in_data = {$urandom, $urandom, $urandom};
  endtask

  task automatic accept_ch0(input logic [LW-1:0] v);
    idle_inputs(); rand_data(); in_data[LW-1:0] = v; in_valid = 1; step();
  endtask

  initial begin
    rst = 1; mode = 0; flush = 0; hold = 0; fill_zero = 0; in_valid = 0; in_data = '0;
    step(); step();
    check("reset buf", buf_data, '0);
    check("reset cnt", fill_cnt, 0);

    // A few lines, then zero-fill beating in_valid
    for (int k = 0; k < 3; k++) accept_ch0(LW'(100 + k));
    idle_inputs(); rand_data(); in_data[LW-1:0] = 16'hABCD; in_valid = 1; fill_zero = 1; step();
    check("zf row0", row(0), 16'h0000);
    check("zf row1", row(1), 16'd102);
    check("zf valid0", row_valid[0], 1'b1);
    check("zf cnt", fill_cnt, 4);

    // Flush, then a full CHAIN fill of 1..10
    idle_inputs(); flush = 1; in_valid = 1; step();
    check("flush valid", row_valid, '0);
    for (int k = 1; k <= 10; k++) accept_ch0(LW'(k));
    check("chain row0", row(0), 16'd10);
    check("chain row9", row(9), 16'd1);
    check("chain valid", row_valid, 10'h3FF);
    check("chain cnt", fill_cnt, 10);
    check("chain primed", primed, 1'b1);

    // Consumer hold for three cycles with a line pending
    idle_inputs(); rand_data(); in_data[LW-1:0] = 16'd11; in_valid = 1; hold = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold ready", in_ready, 1'b0);
      check("hold row0", row(0), 16'd10);
    end
    hold = 0; step();
    check("post-hold row0", row(0), 16'd11);
    check("post-hold row9", row(9), 16'd2);

    // Switch to SPLIT: one dead cycle clears occupancy, data stays
    idle_inputs(); mode = 1; in_valid = 1; step();
    check("mchg valid", row_valid, '0);
    check("mchg primed", primed, 1'b0);
    check("mchg row0", row(0), 16'd11);
    check("mchg row9", row(9), 16'd2);
    for (int k = 1; k <= 2; k++) begin
      idle_inputs(); in_valid = 1;
      for (int c = 0; c < N; c++) in_data[c*LW +: LW] = LW'(16*c + k);
      step();
    end
    for (int c = 0; c < N; c++) begin
      check("split head", row(2*c), LW'(16*c + 2));
      check("split tail", row(2*c+1), LW'(16*c + 1));
    end
    check("split primed", primed, 1'b1);
    check("split cnt", fill_cnt, 2);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      idle_inputs(); rand_data();
      in_valid  = ($urandom_range(0, 9) < 6);
      fill_zero = ($urandom_range(0, 99) < 12);
      hold      = ($urandom_range(0, 99) < 20);
      flush     = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 4) mode = ~mode;
      step();
    end

    // Reset mid-fill
    idle_inputs(); mode = 0; flush = 1; step();
    for (int k = 1; k <= 4; k++) accept_ch0(LW'(k + 40));
    idle_inputs(); rst = 1; in_valid = 1; step();
    check("rst buf", buf_data, '0);
    check("rst cnt", fill_cnt, 0);
    check("rst valid", row_valid, '0);
    idle_inputs(); step();
    check("rst mode_q chain", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
